// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV32I MEM-stage load/store unit on a valid/grant data bus
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses)
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic        fault_misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Count value of the last cycle allowed in REQ+WAIT
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_fault;
  logic        r_mis;
  logic        r_load_valid;
  logic [31:0] r_load_data;

  logic        w_op;
  logic        w_legal;
  logic        w_misalign;
  logic        w_last;
  logic        w_set_fault;
  logic        w_set_mis;
  logic        w_set_ok;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_op   = ex_valid & (mem_read | mem_write);
  // Pipeline released in DONE; held low while reset is asserted
  assign stall  = reset_n & w_op & (r_state != S_DONE);
  assign w_last = (r_cnt >= LP_LAST);

  // Stores allow B/H/W only; loads additionally BU/HU (both-high counts as store)
  assign w_legal = mem_write ? (~funct3[2] & (funct3[1:0] != 2'b11))
                             : ((funct3[1:0] != 2'b11) & ~(funct3[2] & funct3[1]));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Byte-lane strobes and lane-replicated write data for the incoming store
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    w_byte = bus_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = bus_rdata[{r_addr[1], 4'b0000} +: 16];
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h000000, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0000, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state plus the result flags to present in DONE
  always_comb begin
    w_next      = r_state;
    w_set_fault = 1'b0;
    w_set_mis   = 1'b0;
    w_set_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op) begin
          if (!w_legal) begin
            w_next      = S_DONE;
            w_set_fault = 1'b1;
          end else if (w_misalign) begin
            w_next    = S_DONE;
            w_set_mis = 1'b1;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A grant on the last budgeted cycle leaves no room for a response
        if (w_last) begin
          w_next      = S_DONE;
          w_set_fault = 1'b1;
        end else if (bus_gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_err) begin
          w_next      = S_DONE;
          w_set_fault = 1'b1;
        end else if (bus_rvalid) begin
          w_next   = S_DONE;
          w_set_ok = 1'b1;
        end else if (w_last) begin
          w_next      = S_DONE;
          w_set_fault = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Cycles spent in REQ+WAIT for the timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_cnt <= 16'd0;
    else if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
    else                                           r_cnt <= 16'd0;
  end

  // Latch the operation in IDLE and register the DONE-cycle results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= 32'd0;
      r_f3         <= 3'd0;
      r_we         <= 1'b0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_fault      <= 1'b0;
      r_mis        <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'd0;
    end else begin
      if (r_state == S_IDLE && w_op) begin
        r_addr  <= addr;
        r_f3    <= funct3;
        r_we    <= mem_write;
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
      end
      r_fault      <= w_set_fault;
      r_mis        <= w_set_mis;
      r_load_valid <= w_set_ok & ~r_we;
      if (w_set_fault || w_set_mis)  r_load_data <= 32'd0;
      else if (w_set_ok && !r_we)    r_load_data <= w_ext;
    end
  end

  assign bus_req        = (r_state == S_REQ);
  assign bus_we         = r_we;
  assign bus_addr       = {r_addr[31:2], 2'b00};
  assign bus_wdata      = r_wdata;
  assign bus_wstrb      = r_wstrb;
  assign load_data      = r_load_data;
  assign load_valid     = r_load_valid;
  assign fault          = r_fault;
  assign fault_misalign = r_mis;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - self-checking bench for mem_lsu (table vectors plus random ops)
module tb_mem_lsu;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, load_valid, fault, fault_misalign;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid), .fault(fault),
    .fault_misalign(fault_misalign), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rd, wr, f3, addr, sd, rdata, gnt_dly, rsp_dly, err, noise;
    int unsigned exp_stall, exp_ld, exp_lv, exp_fault, exp_mis, exp_req;
    int unsigned exp_baddr, exp_we, exp_wstrb, exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] done, stall, req, ld, lv, fault, mis, baddr, we, wstrb, wdata, after;
  } res_t;

  int total = 0;
  int bad = 0;
  vec_t tbl[18];

  task automatic chk(input string nm, input int unsigned idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  // Expected outcome computed from the access rules: legality, size, lanes, latency budget
  function automatic vec_t model(input vec_t v);
    vec_t e;
    int unsigned size, off, tot, val;
    bit legal, mis;
    e = v;
    e.exp_ld = 0; e.exp_lv = 0; e.exp_fault = 0; e.exp_mis = 0; e.exp_req = 0;
    e.exp_baddr = 0; e.exp_wstrb = 0; e.exp_wdata = 0;
    e.exp_we = v.wr;
    legal = v.wr ? (v.f3 <= 2) : (v.f3 inside {0, 1, 2, 4, 5});
    size = 1 << (v.f3 & 3);
    mis = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (v.addr % size) != 0;
`endif
    if (!legal) begin
      e.exp_fault = 1; e.exp_stall = 1; return e;
    end
    if (mis) begin
      e.exp_mis = 1; e.exp_stall = 1; return e;
    end
    off = ((v.addr % 4) / size) * size;
    e.exp_baddr = v.addr - (v.addr % 4);
    e.exp_wstrb = ((1 << size) - 1) << off;
    e.exp_wdata = (size == 1) ? (v.sd % 256) * 32'h01010101 :
                  (size == 2) ? (v.sd % 65536) * 32'h00010001 : v.sd;
    tot = v.gnt_dly + 1 + v.rsp_dly + 1;
    e.exp_req = (v.gnt_dly + 1 < TO) ? v.gnt_dly + 1 : TO;
    if (tot > TO) begin
      e.exp_fault = 1; e.exp_stall = 1 + TO;
    end else begin
      e.exp_stall = 1 + tot;
      if (v.err != 0) e.exp_fault = 1;
      else if (v.wr == 0) begin
        e.exp_lv = 1;
        val = v.rdata >> (8 * off);
        if (size == 1) begin
          val = val % 256;
          if (v.f3 == 0 && val >= 128) val = val + 32'hFFFFFF00;
        end else if (size == 2) begin
          val = val % 65536;
          if (v.f3 == 1 && val >= 32768) val = val + 32'hFFFF0000;
        end
        e.exp_ld = val;
      end
    end
    return e;
  endfunction

  // Present one op, act as the bus slave, and record what the LSU did until DONE
  task automatic run_op(input vec_t v, output res_t r);
    int req_n, wait_n;
    r = '{default: '0};
    ex_valid = 1'b1; mem_read = v.rd[0]; mem_write = v.wr[0];
    funct3 = v.f3[2:0]; addr = v.addr; store_data = v.sd;
    req_n = 0; wait_n = -1;
    for (int cyc = 0; cyc < 40 && r.done == 0; cyc++) begin
      #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (bus_req) begin
        r.req = r.req + 1;
        r.baddr = bus_addr; r.we = {31'd0, bus_we}; r.wdata = bus_wdata; r.wstrb = {28'd0, bus_wstrb};
        if (req_n == int'(v.gnt_dly)) begin
          bus_gnt = 1'b1; wait_n = 0;
        end
        req_n++;
        if (v.noise != 0) bus_rvalid = 1'b1;
      end else if (wait_n >= 0) begin
        if (wait_n == int'(v.rsp_dly)) begin
          bus_rdata = v.rdata;
          if (v.err != 0) bus_err = 1'b1;
          else            bus_rvalid = 1'b1;
        end
        wait_n++;
      end
      #1;
      if (!stall) begin
        r.done = 1; r.ld = load_data; r.lv = {31'd0, load_valid};
        r.fault = {31'd0, fault}; r.mis = {31'd0, fault_misalign};
      end else begin
        r.stall = r.stall + 1;
      end
      @(posedge clk); #1;
    end
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    #1;
    r.after = {28'd0, load_valid, fault, fault_misalign, stall};
  endtask

  task automatic apply(input vec_t v, input int unsigned idx);
    res_t r;
    run_op(v, r);
    chk("done_reached", idx, r.done, 1);
    chk("stall_cycles", idx, r.stall, v.exp_stall);
    chk("load_valid", idx, r.lv, v.exp_lv);
    chk("fault", idx, r.fault, v.exp_fault);
    chk("fault_misalign", idx, r.mis, v.exp_mis);
    chk("req_cycles", idx, r.req, v.exp_req);
    if (v.exp_lv != 0 || v.exp_fault != 0 || v.exp_mis != 0) chk("load_data", idx, r.ld, v.exp_ld);
    if (v.exp_req != 0) begin
      chk("bus_addr", idx, r.baddr, v.exp_baddr);
      chk("bus_we", idx, r.we, v.exp_we);
      if (v.exp_we != 0) begin
        chk("bus_wstrb", idx, r.wstrb, v.exp_wstrb);
        chk("bus_wdata", idx, r.wdata, v.exp_wdata);
      end
    end
    chk("pulse_cleared", idx, r.after, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    #2 reset_n = 1'b0;
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h104;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", 0, {31'd0, stall}, 0);
    chk("rst_bus_req", 0, {31'd0, bus_req}, 0);
    chk("rst_load_data", 0, load_data, 0);
    chk("rst_flags", 0, {29'd0, load_valid, fault, fault_misalign}, 0);
    chk("rst_bus_out", 0, {27'd0, bus_we, bus_wstrb}, 0);
    chk("rst_bus_addr", 0, bus_addr, 0);
    ex_valid = 1'b0; mem_read = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    //         rd wr f3 addr        sd            rdata        g  r  e  n   stall ld            lv f  m  req baddr     we wstrb    wdata
    tbl[0]  = '{1, 0, 2, 32'h100, 0,            32'hDEADBEEF, 0, 0, 0, 0, 3, 32'hDEADBEEF, 1, 0, 0, 1, 32'h100, 0, 0,       0};
    tbl[1]  = '{1, 0, 0, 32'h103, 0,            32'h80FF1234, 0, 0, 0, 0, 3, 32'hFFFFFF80, 1, 0, 0, 1, 32'h100, 0, 0,       0};
    tbl[2]  = '{1, 0, 4, 32'h103, 0,            32'h80FF1234, 0, 0, 0, 0, 3, 32'h00000080, 1, 0, 0, 1, 32'h100, 0, 0,       0};
    tbl[3]  = '{1, 0, 1, 32'h102, 0,            32'h80FF1234, 0, 0, 0, 0, 3, 32'hFFFF80FF, 1, 0, 0, 1, 32'h100, 0, 0,       0};
    tbl[4]  = '{1, 0, 5, 32'h100, 0,            32'h80FF1234, 1, 2, 0, 1, 6, 32'h00001234, 1, 0, 0, 2, 32'h100, 0, 0,       0};
    tbl[5]  = '{0, 1, 0, 32'h201, 32'h000000AB, 0,            0, 0, 0, 0, 3, 0,            0, 0, 0, 1, 32'h200, 1, 4'b0010, 32'hABABABAB};
    tbl[6]  = '{0, 1, 1, 32'h202, 32'h1234CDEF, 0,            0, 0, 0, 0, 3, 0,            0, 0, 0, 1, 32'h200, 1, 4'b1100, 32'hCDEFCDEF};
    tbl[7]  = '{0, 1, 2, 32'h300, 32'h12345678, 0,            2, 0, 0, 0, 5, 0,            0, 0, 0, 3, 32'h300, 1, 4'b1111, 32'h12345678};
    tbl[8]  = '{1, 0, 2, 32'h400, 0,            32'h55555555, 4, 0, 1, 0, 7, 0,            0, 1, 0, 5, 32'h400, 0, 0,       0};
    tbl[9]  = '{1, 0, 2, 32'h404, 0,            0,           99, 0, 0, 0, 9, 0,            0, 1, 0, 8, 32'h404, 0, 0,       0};
    tbl[10] = '{1, 0, 3, 32'h010, 0,            0,            0, 0, 0, 0, 1, 0,            0, 1, 0, 0, 0,       0, 0,       0};
    tbl[11] = '{0, 1, 3, 32'h010, 32'h11,       0,            0, 0, 0, 0, 1, 0,            0, 1, 0, 0, 0,       0, 0,       0};
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[12] = '{1, 0, 2, 32'h102, 0,            32'hCAFEF00D, 0, 0, 0, 0, 1, 0,            0, 0, 1, 0, 0,       0, 0,       0};
    tbl[16] = '{1, 0, 1, 32'h101, 0,            32'h80FF1234, 0, 0, 0, 0, 1, 0,            0, 0, 1, 0, 0,       0, 0,       0};
`else
    tbl[12] = '{1, 0, 2, 32'h102, 0,            32'hCAFEF00D, 0, 0, 0, 0, 3, 32'hCAFEF00D, 1, 0, 0, 1, 32'h100, 0, 0,       0};
    tbl[16] = '{1, 0, 1, 32'h101, 0,            32'h80FF1234, 0, 0, 0, 0, 3, 32'h00001234, 1, 0, 0, 1, 32'h100, 0, 0,       0};
`endif
    tbl[13] = '{1, 1, 2, 32'h040, 32'hA5A50F0F, 0,            0, 0, 0, 0, 3, 0,            0, 0, 0, 1, 32'h040, 1, 4'b1111, 32'hA5A50F0F};
    tbl[14] = '{1, 0, 2, 32'h600, 0,            32'h13579BDF, 1, 5, 0, 0, 9, 32'h13579BDF, 1, 0, 0, 2, 32'h600, 0, 0,       0};
    tbl[15] = '{1, 0, 2, 32'h604, 0,            32'h2468ACE0, 7, 0, 0, 0, 9, 0,            0, 1, 0, 8, 32'h604, 0, 0,       0};
    tbl[17] = '{1, 0, 6, 32'h020, 0,            0,            0, 0, 0, 0, 1, 0,            0, 1, 0, 0, 0,       0, 0,       0};
    for (int i = 0; i < 18; i++) apply(tbl[i], i);

    // Reset asserted while waiting for a response; a late response must be ignored
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h500;
    #1 chk("rw_stall_idle", 100, {31'd0, stall}, 1);
    @(posedge clk); #1;
    chk("rw_req", 100, {31'd0, bus_req}, 1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    chk("rw_wait_req", 100, {31'd0, bus_req}, 0);
    chk("rw_wait_stall", 100, {31'd0, stall}, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_rst_stall", 100, {31'd0, stall}, 0);
    chk("rw_rst_addr", 100, bus_addr, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; ex_valid = 1'b0; mem_read = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("rw_late_flags", 101 + c, {28'd0, load_valid, fault, stall, bus_req}, 0);
      chk("rw_late_data", 101 + c, load_data, 0);
      @(posedge clk); #1;
    end
    bus_rvalid = 1'b0;
    apply(tbl[0], 104);

    // Random ops checked against the rule-level model
    for (int i = 0; i < 60; i++) begin
      v = '{default: 0};
      case ($urandom_range(0, 3))
        0, 3:    begin v.rd = 1; v.wr = 0; end
        1:       begin v.rd = 0; v.wr = 1; end
        default: begin v.rd = 1; v.wr = 1; end
      endcase
      v.f3 = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2) + 4 * ($urandom_range(0, 1) & v.rd & ~v.wr);
      v.addr = $urandom;
      v.sd = $urandom;
      v.rdata = $urandom;
      v.gnt_dly = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 2);
      v.rsp_dly = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 2);
      v.err = ($urandom_range(0, 7) == 0) ? 1 : 0;
      v.noise = $urandom_range(0, 1);
      v = model(v);
      apply(v, 200 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
